// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int div_calc(input int clock, input int rate);
        return clock / rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud clock-enable: counts 0..DIV-1 and pulses tick on the last count.
module uart_baud_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // clear realigns the bit grid to the start of a new frame
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable-frame UART transmitter with valid/ready input.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO.
module uart_tx_frame #(
    parameter int CLOCK      = 50000000,
    parameter int RATE       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    import uart_pkg::*;

    localparam int DIV = div_calc(CLOCK, RATE);

    tx_state_t            state, next_state;
    logic [DATA_BITS-1:0] shifter, shift_next, head_data;
    logic [2:0]           bit_cnt, bit_next;
    logic                 par_q, txd_next, tick, load, push, pending, ready_en, full;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .tick  (tick)
    );

    // A character moves on tx_valid && tx_ready at a posedge; producer holds tx_data until then.
    assign push     = tx_valid && tx_ready;
    assign tx_ready = ready_en && !full;
    assign busy     = (state != IDLE) || pending;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;

    // Extra pointer MSB distinguishes full from empty
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pending   = (wr_ptr != rd_ptr);
    assign head_data = mem[rd_ptr[AW-1:0]];
    assign level     = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= tx_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full;

    assign full      = hold_full;
    assign pending   = hold_full;
    assign head_data = hold_q;
    assign level     = '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold_q    <= tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            shifter  <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            txd      <= 1'b1;
            ready_en <= 1'b0;
        end else begin
            state    <= next_state;
            shifter  <= shift_next;
            bit_cnt  <= bit_next;
            txd      <= txd_next;
            ready_en <= 1'b1;
            if (load) begin
                par_q <= (^head_data) ^ (PARITY == PAR_ODD);
            end
        end
    end

    always_comb begin
        next_state = state;
        shift_next = shifter;
        bit_next   = bit_cnt;
        load       = 1'b0;
        txd_next   = 1'b1;
        case (state)
            IDLE: begin
                if (pending) begin
                    next_state = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    next_state = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shifter >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        next_state = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    next_state = STOP;
                    bit_next   = '0;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when a character is waiting
                if (tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_next = '0;
                        if (pending) begin
                            next_state = START;
                            load       = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (load) begin
            shift_next = head_data;
        end
        case (next_state)
            START:            txd_next = 1'b0;
            DATA:             txd_next = shift_next[0];
            uart_pkg::PARITY: txd_next = par_q;
            default:          txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three frame formats, expected line bits kept in a queue.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       txd_a, txd_b, txd_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] level_a, level_b, level_c;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    logic [0:0] exp_q[$];

    uart_tx_frame #(.CLOCK(16), .RATE(1)) u_a (
        .clk(clk), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .txd(txd_a), .busy(busy_a), .level(level_a)
    );
    uart_tx_frame #(.CLOCK(4), .RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .txd(txd_b), .busy(busy_b), .level(level_b)
    );
    uart_tx_frame #(.CLOCK(4), .RATE(1), .PARITY(1)) u_c (
        .clk(clk), .reset(reset), .tx_data(data_c), .tx_valid(valid_c),
        .tx_ready(ready_c), .txd(txd_c), .busy(busy_c), .level(level_c)
    );

    function automatic logic mon_txd();
        case (sel) 0: return txd_a; 1: return txd_b; default: return txd_c; endcase
    endfunction
    function automatic logic mon_ready();
        case (sel) 0: return ready_a; 1: return ready_b; default: return ready_c; endcase
    endfunction
    function automatic logic mon_busy();
        case (sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic logic mon_valid();
        case (sel) 0: return valid_a; 1: return valid_b; default: return valid_c; endcase
    endfunction
    function automatic int mon_div();
        return (sel == 0) ? 16 : 4;
    endfunction

    task automatic set_valid(input logic v);
        case (sel) 0: valid_a = v; 1: valid_b = v; default: valid_c = v; endcase
    endtask
    task automatic set_data(input logic [7:0] d);
        case (sel) 0: data_a = d; 1: data_b = d[6:0]; default: data_c = d; endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // One clock; drops tx_valid once the posedge has taken the character.
    task automatic step();
        logic hs;
        hs = mon_valid() && mon_ready();
        @(negedge clk);
        if (hs) set_valid(1'b0);
    endtask

    task automatic push_frame(input logic [7:0] d);
        int nd, par, ns;
        logic p;
        nd  = (sel == 1) ? 7 : 8;
        par = (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
        ns  = (sel == 1) ? 2 : 1;
        p   = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
        if (par == 2) exp_q.push_back(p);
        if (par == 1) exp_q.push_back(~p);
        for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        set_data(d);
        set_valid(1'b1);
        push_frame(d);
        while (!mon_ready() && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", mon_ready(), 1);
        @(negedge clk);
        set_valid(1'b0);
    endtask

    // Each bit must hold its value from its first to its last cycle (exactly DIV cycles).
    task automatic check_frame(input int nbits, input int skip, output int w,
                               output logic last_busy, output logic mid_ready);
        int d;
        logic f, l;
        logic [0:0] e;
        d = mon_div();
        w = 0;
        last_busy = 1'bx;
        mid_ready = 1'bx;
        while (mon_txd() !== 1'b0 && w < 4000) begin
            step();
            w++;
        end
        chk("start_seen", mon_txd(), 0);
        if (mon_txd() !== 1'b0) begin
            for (int i = 0; i < nbits; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            f = mon_txd();
            repeat (d - 1 - ((i == 0) ? skip : 0)) step();
            l = mon_txd();
            last_busy = mon_busy();
            if (i == nbits / 2) mid_ready = mon_ready();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            chk($sformatf("bit%0d", i), {f, l}, {e, e});
            step();
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic lb, rm;
        logic [7:0] fifo_vals [5];

        reset = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_level", level_a, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready_a, 1);

        // 8N1, DIV=16: 0x55
        sel = 0;
        send(8'h55);
        chk("pre_start_txd", txd_a, 1);
        chk("pending_busy", busy_a, 1);
        check_frame(10, 0, w, lb, rm);
        chk("latency_55", w, 1);
        chk("mid_ready_55", rm, 1);
        chk("busy_last_cycle", lb, 1);
        chk("busy_drop", busy_a, 0);
        chk("idle_txd", txd_a, 1);
        chk("level_nofifo", level_a, 0);

        // 7E2: 0x07
        sel = 1;
        send(8'h07);
        check_frame(11, 0, w, lb, rm);
        chk("latency_7e2", w, 1);
        chk("busy_drop_7e2", busy_b, 0);

        // 8O1 parity cases
        sel = 2;
        send(8'h00);
        check_frame(11, 0, w, lb, rm);
        send(8'hFF);
        check_frame(11, 0, w, lb, rm);
        send(8'h01);
        check_frame(11, 0, w, lb, rm);
        chk("busy_drop_8o1", busy_c, 0);

        // Back-to-back: second character queued behind the first
        sel = 0;
        send(8'hA5);
        set_data(8'h3C);
        set_valid(1'b1);
        push_frame(8'h3C);
        check_frame(10, 0, w, lb, rm);
        chk("b2b_mid_ready_low", rm, 0);
        check_frame(10, 0, w, lb, rm);
        chk("b2b_no_gap", w, 0);
        chk("b2b_busy_drop", busy_a, 0);
        chk("b2b_valid_dropped", valid_a, 0);

        // Reset in the middle of the data bits of 0xF0
        send(8'hF0);
        w = 0;
        while (txd_a !== 1'b0 && w < 100) begin
            step();
            w++;
        end
        repeat (16 * 3 + 5) step();
        chk("mid_data_busy", busy_a, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_txd", txd_a, 1);
        chk("abort_busy", busy_a, 0);
        chk("abort_level", level_a, 0);
        chk("abort_ready", ready_a, 0);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        send(8'hC3);
        check_frame(10, 0, w, lb, rm);
        chk("post_abort_latency", w, 1);
        chk("post_abort_idle", busy_a, 0);

`ifdef UART_TX_FIFO_EN
        // Five pushes on consecutive cycles: one drains into the shifter, four fill the FIFO
        fifo_vals = '{8'h11, 8'h92, 8'h3E, 8'hC4, 8'h5A};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fifo_push_ready%0d", k), ready_a, 1);
            set_data(fifo_vals[k]);
            set_valid(1'b1);
            push_frame(fifo_vals[k]);
            step();
        end
        chk("fifo_level_full", level_a, 4);
        chk("fifo_ready_full", ready_a, 0);
        check_frame(10, 3, w, lb, rm);
        chk("fifo_first_started", w, 0);
        for (int k = 1; k < 5; k++) begin
            check_frame(10, 0, w, lb, rm);
            chk($sformatf("fifo_no_gap%0d", k), w, 0);
        end
        chk("fifo_level_empty", level_a, 0);
        chk("fifo_busy_drop", busy_a, 0);
`else
        fifo_vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
